// File: rtl/smol_pkg.sv
// Shared fetch-stage types and constants for smolCore.
package smol_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] instr;
    logic [DEF_ADDR_WIDTH+1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/smol_fetch_buf.sv
// Two-entry fetch FIFO; head is registered so id_* is stable while stalled.
// Simultaneous push/pop allowed at count 1 or 2; flush empties it in one cycle.
module smol_fetch_buf
  import smol_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output entry_t     head
);
  entry_t tail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
      if (flush) count <= 2'd0;
    end
  end

  // Issue throttling guarantees a full buffer is never pushed without a pop.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count == 2'd2));
endmodule

// File: rtl/smol_fetch.sv
// smolCore fetch: PC, IMEM request (data one cycle later), 2-entry decode buffer, redirects.
// Optional perf counters under SMOL_FETCH_PERF_EN; issue halts when buffer+inflight would overflow.
module smol_fetch
  import smol_pkg::*;
#(
  parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RESET_PC   = DEF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH+1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH+1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH+1:0] id_pc
`ifdef SMOL_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);
  localparam int PCW = ADDR_WIDTH + 2;
  localparam logic [PCW-1:0] RST_PC = PCW'(RESET_PC);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [PCW-1:0]        pc;
  } entry_t;

  logic [PCW-1:0] pc;
  logic [PCW-1:0] req_pc;
  logic           inflight;
  logic [1:0]     count;
  logic [1:0]     occupancy;
  logic           pop;
  logic           push;
  logic           issue;
  entry_t         push_ent;
  entry_t         head;

  assign imem_addr = pc;
  assign pop       = id_valid & id_ready;
  assign occupancy = count + {1'b0, inflight};
  assign issue     = !redirect_valid && (occupancy < 2'd2 || (occupancy == 2'd2 && pop));
  assign push      = inflight & !redirect_valid;

  assign push_ent.instr = imem_instr;
  assign push_ent.pc    = req_pc;

  smol_fetch_buf #(.entry_t(entry_t)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign id_valid = (count != 2'd0);
  assign id_instr = head.instr;
  assign id_pc    = head.pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RST_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~PCW'(3);
      inflight <= 1'b0;
    end else if (issue) begin
      req_pc   <= pc;
      pc       <= pc + PCW'(INSTR_BYTES);
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

`ifdef SMOL_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_valid && !id_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
